j11dl11: RTL and testbench

- DL11-style console serial register responder; sits on the UART slave port of the J11 memory router.
- Decodes 16-bit I/O accesses to four registers, nominal octal addresses 177560–177566: RCSR, RBUF, XCSR, XBUF.
- Buffers received bytes in a small FIFO and hands transmit bytes to a byte-stream serializer.
- Raises receive and transmit interrupt request levels.

---
 rtl/j11dl11.sv | 107 ++++++++++
 tb/tb_j11dl11.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/j11dl11.sv
// j11dl11: DL11-style console register responder with receive FIFO, transmit handoff and loopback
module j11dl11 #(
  parameter int RXDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uartreq,
  input  logic [2:0]  uartaddr,
  input  logic        uartwr,
  input  logic [15:0] uartwdata,
  output logic        uartack,
  output logic [15:0] uartrdata,
  input  logic        rxstb,
  input  logic [7:0]  rxdata,
  output logic        txvalid,
  output logic [7:0]  txdata,
  input  logic        txready,
  output logic        rxirq,
  output logic        txirq
);
  localparam int AW = $clog2(RXDEPTH);
  logic [7:0]    mem_q [RXDEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d, wp2;
  logic [AW:0]   cnt_q, cnt_d, room;
  logic          ovr_q, ovr_d, rie_q, rie_d, tie_q, tie_d, maint_q, maint_d;
  logic          ready_q, ready_d, txv_q, txv_d, lb_q, lb_d, ack_q, ack_d;
  logic [7:0]    txb_q, txb_d, head;
  logic [15:0]   rdata_q, rdata_d;
  logic [1:0]    sel;
  logic          wr, rd, done, pop, ok1, ok2, xw, rbuf_rd;
  logic          unused_ok;
  assign unused_ok = ^{uartaddr[0], uartwdata[15:8]};
  // Decode accesses, arbitrate FIFO pushes/pop, and compute next register state
  always_comb begin
    sel     = uartaddr[2:1];
    wr      = uartreq & uartwr;
    rd      = uartreq & ~uartwr;
    done    = cnt_q != '0;
    head    = done ? mem_q[rp_q] : 8'h00;
    rbuf_rd = rd & (sel == 2'd1);
    pop     = rbuf_rd & done;
    room    = (AW+1)'(RXDEPTH) - cnt_q + (AW+1)'(pop);
    ok1     = rxstb & (room != '0);
    ok2     = lb_q & ((room - (AW+1)'(ok1)) != '0);
    wp2     = ok1 ? wp_q + AW'(1) : wp_q;
    cnt_d   = cnt_q + (AW+1)'(ok1) + (AW+1)'(ok2) - (AW+1)'(pop);
    wp_d    = wp_q + AW'(ok1) + AW'(ok2);
    rp_d    = rp_q + AW'(pop);
    ovr_d   = (ovr_q & ~rbuf_rd) | (rxstb & ~ok1) | (lb_q & ~ok2);
    rie_d   = (wr & (sel == 2'd0)) ? uartwdata[6] : rie_q;
    tie_d   = (wr & (sel == 2'd2)) ? uartwdata[6] : tie_q;
    maint_d = (wr & (sel == 2'd2)) ? uartwdata[2] : maint_q;
    xw      = wr & (sel == 2'd3) & ready_q;
    txb_d   = xw ? uartwdata[7:0] : txb_q;
    txv_d   = xw ? ~maint_q : txv_q & ~txready;
    lb_d    = xw & maint_q;
    ready_d = xw ? 1'b0 : ready_q | (txv_q & txready) | lb_q;
    ack_d   = uartreq;
    rdata_d = !rd ? 16'h0000 :
              sel == 2'd0 ? {8'h00, done, rie_q, 6'b0} :
              sel == 2'd1 ? {ovr_q, ovr_q, 6'b0, head} :
              sel == 2'd2 ? {8'h00, ready_q, tie_q, 3'b0, maint_q, 2'b0} : 16'h0000;
  end
  // Register state; reset overrides every other event
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      rie_q   <= 1'b0;
      tie_q   <= 1'b0;
      maint_q <= 1'b0;
      ready_q <= 1'b1;
      txv_q   <= 1'b0;
      lb_q    <= 1'b0;
      txb_q   <= 8'h00;
      ack_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      rie_q   <= rie_d;
      tie_q   <= tie_d;
      maint_q <= maint_d;
      ready_q <= ready_d;
      txv_q   <= txv_d;
      lb_q    <= lb_d;
      txb_q   <= txb_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end
  // FIFO storage: received byte lands first, loopback byte behind it
  always_ff @(posedge clk) begin
    if (ok1) mem_q[wp_q] <= rxdata;
    if (ok2) mem_q[wp2] <= txb_q;
  end
  assign uartack   = ack_q & ~rst;
  assign uartrdata = rst ? 16'h0000 : rdata_q;
  assign txvalid   = txv_q;
  assign txdata    = txb_q;
  assign rxirq     = done & rie_q;
  assign txirq     = ready_q & tie_q;
endmodule

// File: tb/tb_j11dl11.sv
// tb_j11dl11: directed self-checking bench for the DL11 console responder
module tb_j11dl11;
  logic        clk, rst, uartreq, uartwr, uartack, rxstb, txvalid, txready, rxirq, txirq;
  logic [2:0]  uartaddr;
  logic [15:0] uartwdata, uartrdata;
  logic [7:0]  rxdata, txdata;
  int vecs = 0;
  int errs = 0;

  j11dl11 #(.RXDEPTH(4)) dut (
    .clk(clk), .rst(rst), .uartreq(uartreq), .uartaddr(uartaddr), .uartwr(uartwr),
    .uartwdata(uartwdata), .uartack(uartack), .uartrdata(uartrdata), .rxstb(rxstb),
    .rxdata(rxdata), .txvalid(txvalid), .txdata(txdata), .txready(txready),
    .rxirq(rxirq), .txirq(txirq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk) rst = 1;
    @(negedge clk);
    @(negedge clk) rst = 0;
  endtask

  task automatic access(input logic [2:0] a, input logic w, input logic [15:0] d,
                        output logic ack, output logic [15:0] rdat);
    @(negedge clk);
    uartreq = 1; uartaddr = a; uartwr = w; uartwdata = d;
    @(negedge clk);
    uartreq = 0; uartwr = 0;
    ack = uartack; rdat = uartrdata;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk) rxstb = 1; rxdata = b;
    @(negedge clk) rxstb = 0;
  endtask

  task automatic test_reset();
    logic a; logic [15:0] r;
    do_reset();
    vecs++;
    if ({uartack, txvalid, rxirq, txirq, txdata, uartrdata} !== 28'h0) begin
      errs++; $display("FAIL reset_outputs got %h exp 0", {uartack, txvalid, rxirq, txirq, txdata, uartrdata});
    end
    access(3'd4, 0, 0, a, r);
    vecs++;
    if (a !== 1 || r !== 16'o000200 || txvalid !== 0) begin
      errs++; $display("FAIL reset_xcsr got ack=%b rd=%o txv=%b exp 1 000200 0", a, r, txvalid);
    end
    @(negedge clk);
    vecs++;
    if (uartack !== 0) begin errs++; $display("FAIL ack_one_cycle got %b exp 0", uartack); end
  endtask

  task automatic test_rx();
    logic a; logic [15:0] r;
    strobe(8'h41);
    access(3'd0, 0, 0, a, r);
    vecs++;
    if (r !== 16'o000200) begin errs++; $display("FAIL rx_rcsr_done got %o exp 000200", r); end
    access(3'd2, 0, 0, a, r);
    vecs++;
    if (r !== 16'h0041) begin errs++; $display("FAIL rx_rbuf got %h exp 0041", r); end
    access(3'd0, 0, 0, a, r);
    vecs++;
    if (r !== 16'h0000) begin errs++; $display("FAIL rx_rcsr_empty got %o exp 0", r); end
  endtask

  task automatic test_rxirq();
    logic a; logic [15:0] r;
    access(3'd0, 1, 16'o000100, a, r);
    vecs++;
    if (a !== 1 || r !== 16'h0000 || rxirq !== 0) begin
      errs++; $display("FAIL rie_write got ack=%b rd=%h irq=%b exp 1 0000 0", a, r, rxirq);
    end
    strobe(8'h0D);
    vecs++;
    if (rxirq !== 1) begin errs++; $display("FAIL rxirq_set got %b exp 1", rxirq); end
    access(3'd0, 0, 0, a, r);
    vecs++;
    if (r !== 16'o000300) begin errs++; $display("FAIL rcsr_rie got %o exp 000300", r); end
    access(3'd2, 0, 0, a, r);
    vecs++;
    if (r !== 16'h000D || rxirq !== 0) begin
      errs++; $display("FAIL rxirq_clear got rd=%h irq=%b exp 000d 0", r, rxirq);
    end
    access(3'd0, 1, 16'hFFFF, a, r);
    access(3'd0, 0, 0, a, r);
    vecs++;
    if (r !== 16'o000100) begin errs++; $display("FAIL rcsr_mask got %o exp 000100", r); end
    access(3'd0, 1, 16'h0000, a, r);
  endtask

  task automatic test_tx();
    logic a; logic [15:0] r;
    txready = 0;
    access(3'd6, 1, 16'h1234, a, r);
    vecs++;
    if (txvalid !== 1 || txdata !== 8'h34) begin
      errs++; $display("FAIL tx_start got v=%b d=%h exp 1 34", txvalid, txdata);
    end
    access(3'd4, 0, 0, a, r);
    vecs++;
    if (r !== 16'h0000) begin errs++; $display("FAIL tx_busy_xcsr got %o exp 0", r); end
    access(3'd6, 1, 16'h0055, a, r);
    vecs++;
    if (a !== 1 || txdata !== 8'h34 || txvalid !== 1) begin
      errs++; $display("FAIL tx_ignored got ack=%b d=%h v=%b exp 1 34 1", a, txdata, txvalid);
    end
    access(3'd6, 0, 0, a, r);
    vecs++;
    if (r !== 16'h0000) begin errs++; $display("FAIL xbuf_read got %h exp 0", r); end
    @(negedge clk) txready = 1;
    @(negedge clk) txready = 0;
    vecs++;
    if (txvalid !== 0) begin errs++; $display("FAIL tx_handshake got v=%b exp 0", txvalid); end
    access(3'd4, 0, 0, a, r);
    vecs++;
    if (r !== 16'o000200) begin errs++; $display("FAIL tx_ready got %o exp 000200", r); end
    access(3'd4, 1, 16'o000100, a, r);
    vecs++;
    if (txirq !== 1) begin errs++; $display("FAIL txirq got %b exp 1", txirq); end
    access(3'd4, 1, 16'h0000, a, r);
    vecs++;
    if (txirq !== 0) begin errs++; $display("FAIL txirq_off got %b exp 0", txirq); end
  endtask

  task automatic test_overrun();
    logic a; logic [15:0] r;
    logic [15:0] exp_q [5] = '{16'o140001, 16'h0002, 16'h0003, 16'h0004, 16'h0000};
    @(negedge clk) rxstb = 1;
    for (int i = 1; i <= 5; i++) begin
      rxdata = 8'(i);
      @(negedge clk);
    end
    rxstb = 0;
    access(3'd0, 0, 0, a, r);
    vecs++;
    if (r !== 16'o000200) begin errs++; $display("FAIL ovr_done got %o exp 000200", r); end
    for (int i = 0; i < 5; i++) begin
      access(3'd2, 0, 0, a, r);
      vecs++;
      if (r !== exp_q[i]) begin errs++; $display("FAIL ovr_read%0d got %o exp %o", i, r, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic a; logic [15:0] r;
    for (int i = 1; i <= 4; i++) strobe(8'(i));
    @(negedge clk);
    uartreq = 1; uartaddr = 3'd2; uartwr = 0; rxstb = 1; rxdata = 8'h05;
    @(negedge clk);
    uartreq = 0; rxstb = 0;
    vecs++;
    if (uartack !== 1 || uartrdata !== 16'h0001) begin
      errs++; $display("FAIL pop_push got ack=%b rd=%o exp 1 000001", uartack, uartrdata);
    end
    for (int i = 2; i <= 5; i++) begin
      access(3'd2, 0, 0, a, r);
      vecs++;
      if (r !== 16'(i)) begin errs++; $display("FAIL pop_push_read%0d got %o exp %0d", i, r, i); end
    end
  endtask

  task automatic test_loopback();
    logic a; logic [15:0] r;
    access(3'd4, 1, 16'o000004, a, r);
    access(3'd6, 1, 16'h007A, a, r);
    vecs++;
    if (txvalid !== 0) begin errs++; $display("FAIL lb_txvalid got %b exp 0", txvalid); end
    access(3'd0, 0, 0, a, r);
    vecs++;
    if (r !== 16'o000200) begin errs++; $display("FAIL lb_done got %o exp 000200", r); end
    access(3'd2, 0, 0, a, r);
    vecs++;
    if (r !== 16'h007A) begin errs++; $display("FAIL lb_rbuf got %h exp 007a", r); end
    access(3'd4, 0, 0, a, r);
    vecs++;
    if (r !== 16'o000204) begin errs++; $display("FAIL lb_xcsr got %o exp 000204", r); end
    access(3'd4, 1, 16'h0000, a, r);
  endtask

  task automatic test_reset_pending();
    logic a; logic [15:0] r;
    txready = 0;
    access(3'd6, 1, 16'h0099, a, r);
    vecs++;
    if (txvalid !== 1) begin errs++; $display("FAIL pend_start got %b exp 1", txvalid); end
    do_reset();
    vecs++;
    if (txvalid !== 0 || txdata !== 8'h00) begin
      errs++; $display("FAIL pend_discard got v=%b d=%h exp 0 00", txvalid, txdata);
    end
    @(negedge clk);
    uartreq = 1; uartaddr = 3'd4; uartwr = 0;
    @(negedge clk);
    uartreq = 0; rst = 1;
    #1;
    vecs++;
    if (uartack !== 0 || uartrdata !== 16'h0000) begin
      errs++; $display("FAIL rst_ack got ack=%b rd=%h exp 0 0000", uartack, uartrdata);
    end
    @(negedge clk) rst = 0;
    @(negedge clk);
    vecs++;
    if (uartack !== 0) begin errs++; $display("FAIL rst_ack_late got %b exp 0", uartack); end
  endtask

  initial begin
    rst = 1; uartreq = 0; uartaddr = 0; uartwr = 0; uartwdata = 0;
    rxstb = 0; rxdata = 0; txready = 0;
    test_reset();
    test_rx();
    test_rxirq();
    test_tx();
    test_overrun();
    test_back_to_back();
    test_loopback();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
